// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD pixel scheduler: FSM states, job types, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

   localparam int FRAME_PIXELS_DEF = 76800;   // 320 x 240
   localparam int PIX_W            = 16;      // RGB565
   localparam int IDX_W            = 17;      // enough for one full frame index

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      JOB_NONE    = 2'd0,
      JOB_CPU     = 2'd1,
      JOB_FILL    = 2'd2,
      JOB_RESTART = 2'd3
   } job_t;

endpackage

// File: rtl/lcd_pixel_sched_if.sv
// LCD driver side of the pixel scheduler: request strobes, pixel value, busy flag.
// Latency: n/a (wires only).
// Backpressure: lcd_busy from the driver stalls every new request.
// Ports: master = scheduler (drives pix_clk/reset_cursor/pix_data), slave = LCD driver.
interface lcd_pixel_sched_if;
   import lcd_pkg::*;

   logic             pix_clk;
   logic             reset_cursor;
   logic [PIX_W-1:0] pix_data;
   logic             lcd_busy;

   modport master (output pix_clk, output reset_cursor, output pix_data, input lcd_busy);
   modport slave  (input pix_clk, input reset_cursor, input pix_data, output lcd_busy);
endinterface

// File: rtl/lcd_req_handshake.sv
// Request/acknowledge FSM toward the LCD driver: IDLE -> ISSUE -> DRAIN -> IDLE.
// Latency: request rises the cycle after a job is offered; done_o fires on DRAIN exit.
// Backpressure: holds the request until lcd_busy is seen high, then waits for it to clear.
// Ports: job_i (JOB_NONE = nothing offered), lcd_busy_i; state_o, job_o (job in flight),
//        pix_clk_o / reset_cursor_o (registered requests), done_o (combinational DRAIN exit).
module lcd_req_handshake
   import lcd_pkg::*;
(
   input  logic   clk_16MHz,
   input  logic   resetn,
   input  job_t   job_i,
   input  logic   lcd_busy_i,
   output state_t state_o,
   output job_t   job_o,
   output logic   pix_clk_o,
   output logic   reset_cursor_o,
   output logic   done_o
);

   state_t state_q, state_d;
   job_t   job_q, job_d;
   logic   pix_clk_q, pix_clk_d;
   logic   rst_cur_q, rst_cur_d;

   always_ff @(posedge clk_16MHz) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         job_q     <= JOB_NONE;
         pix_clk_q <= 1'b0;
         rst_cur_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         job_q     <= job_d;
         pix_clk_q <= pix_clk_d;
         rst_cur_q <= rst_cur_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      job_d     = job_q;
      pix_clk_d = pix_clk_q;
      rst_cur_d = rst_cur_q;
      done_o    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!lcd_busy_i && job_i != JOB_NONE) begin
               state_d   = ST_ISSUE;
               job_d     = job_i;
               // exactly one of the two strobes per job
               pix_clk_d = (job_i != JOB_RESTART);
               rst_cur_d = (job_i == JOB_RESTART);
            end
         end
         ST_ISSUE: begin
            if (lcd_busy_i) begin
               state_d   = ST_DRAIN;
               pix_clk_d = 1'b0;
               rst_cur_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (!lcd_busy_i) begin
               state_d = ST_IDLE;
               done_o  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign state_o        = state_q;
   assign job_o          = job_q;
   assign pix_clk_o      = pix_clk_q;
   assign reset_cursor_o = rst_cur_q;

endmodule

// File: rtl/lcd_pixel_sched.sv
// Schedules CPU pixel writes, solid fills and cursor restarts onto one LCD driver port.
// Latency: pixel request rises the cycle after a job is chosen; index/fill count update on DRAIN exit.
// Backpressure: cpu_ready low while busy, a restart is pending or a fill is running.
// Ports: cpu_valid/cpu_pix/cpu_ready (CPU write), fill_start/color/count -> fill_busy/fill_done,
//        frame_restart, pix_index (next frame pixel), lcd (driver handshake, master side).
module lcd_pixel_sched
   import lcd_pkg::*;
#(
   parameter int FRAME_PIXELS = FRAME_PIXELS_DEF
)(
   input  logic               clk_16MHz,
   input  logic               resetn,
   input  logic               cpu_valid,
   input  logic [PIX_W-1:0]   cpu_pix,
   output logic               cpu_ready,
   input  logic               fill_start,
   input  logic [PIX_W-1:0]   fill_color,
   input  logic [IDX_W-1:0]   fill_count,
   output logic               fill_busy,
   output logic               fill_done,
   input  logic               frame_restart,
   output logic [IDX_W-1:0]   pix_index,
   lcd_pixel_sched_if.master  lcd
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

   logic [PIX_W-1:0] pix_data_q,   pix_data_d;
   logic [IDX_W-1:0] pix_index_q,  pix_index_d;
   logic [IDX_W-1:0] fill_left_q,  fill_left_d;
   logic [PIX_W-1:0] fill_color_q, fill_color_d;
   logic             fill_busy_q,  fill_busy_d;
   logic             fill_done_q,  fill_done_d;
   logic             rst_pend_q,   rst_pend_d;

   state_t hs_state;
   job_t   hs_job;
   job_t   sel_job;
   logic   hs_done, hs_pix_clk, hs_rst_cur;
   logic   restart_now, idle_free;

   // A restart pulse arriving this cycle already outranks the CPU, so it is
   // folded into the pending flag before arbitration.
   assign restart_now = rst_pend_q | frame_restart;
   assign idle_free   = (hs_state == ST_IDLE) && !lcd.lcd_busy;
   assign cpu_ready   = idle_free && !restart_now && !fill_busy_q;

   always_comb begin
      sel_job = JOB_NONE;
      if (idle_free) begin
         if (restart_now)      sel_job = JOB_RESTART;
         else if (fill_busy_q) sel_job = JOB_FILL;
         else if (cpu_valid)   sel_job = JOB_CPU;
      end
   end

   lcd_req_handshake u_hs (
      .clk_16MHz      (clk_16MHz),
      .resetn         (resetn),
      .job_i          (sel_job),
      .lcd_busy_i     (lcd.lcd_busy),
      .state_o        (hs_state),
      .job_o          (hs_job),
      .pix_clk_o      (hs_pix_clk),
      .reset_cursor_o (hs_rst_cur),
      .done_o         (hs_done)
   );

   always_comb begin
      pix_data_d   = pix_data_q;
      pix_index_d  = pix_index_q;
      fill_left_d  = fill_left_q;
      fill_color_d = fill_color_q;
      fill_busy_d  = fill_busy_q;
      fill_done_d  = 1'b0;
      rst_pend_d   = restart_now && (sel_job != JOB_RESTART);

      // pix_data only changes when a pixel job is launched, so it stays put
      // through ISSUE and DRAIN (driver samples the low byte late).
      if (sel_job == JOB_CPU)       pix_data_d = cpu_pix;
      else if (sel_job == JOB_FILL) pix_data_d = fill_color_q;

      if (fill_start && !fill_busy_q) begin
         fill_color_d = fill_color;
         fill_left_d  = fill_count;
         fill_busy_d  = (fill_count != '0);
         fill_done_d  = (fill_count == '0);
      end

      if (hs_done) begin
         if (hs_job == JOB_RESTART)     pix_index_d = '0;
         else if (pix_index_q == LAST_IDX) pix_index_d = '0;
         else                           pix_index_d = pix_index_q + 1'b1;

         if (hs_job == JOB_FILL) begin
            fill_left_d = fill_left_q - 1'b1;
            if (fill_left_q == IDX_W'(1)) begin
               fill_busy_d = 1'b0;
               fill_done_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_16MHz) begin
      if (!resetn) begin
         pix_data_q   <= '0;
         pix_index_q  <= '0;
         fill_left_q  <= '0;
         fill_color_q <= '0;
         fill_busy_q  <= 1'b0;
         fill_done_q  <= 1'b0;
         rst_pend_q   <= 1'b0;
      end else begin
         pix_data_q   <= pix_data_d;
         pix_index_q  <= pix_index_d;
         fill_left_q  <= fill_left_d;
         fill_color_q <= fill_color_d;
         fill_busy_q  <= fill_busy_d;
         fill_done_q  <= fill_done_d;
         rst_pend_q   <= rst_pend_d;
      end
   end

   assign lcd.pix_clk      = hs_pix_clk;
   assign lcd.reset_cursor = hs_rst_cur;
   assign lcd.pix_data     = pix_data_q;
   assign fill_busy        = fill_busy_q;
   assign fill_done        = fill_done_q;
   assign pix_index        = pix_index_q;

endmodule

// File: tb/tb_lcd_pixel_sched.sv
// Directed bench for lcd_pixel_sched; bench plays the LCD driver by hand.
// The frame is shrunk to 8 pixels so the index wrap is reachable in a short run.
// All inputs driven on the falling edge, outputs checked there too.
module tb_lcd_pixel_sched;
   import lcd_pkg::*;

   localparam int FP = 8;

   logic              clk_16MHz;
   logic              resetn;
   logic              cpu_valid;
   logic [15:0]       cpu_pix;
   logic              cpu_ready;
   logic              fill_start;
   logic [15:0]       fill_color;
   logic [16:0]       fill_count;
   logic              fill_busy;
   logic              fill_done;
   logic              frame_restart;
   logic [16:0]       pix_index;

   lcd_pixel_sched_if lcd();

   lcd_pixel_sched #(.FRAME_PIXELS(FP)) dut (
      .clk_16MHz     (clk_16MHz),
      .resetn        (resetn),
      .cpu_valid     (cpu_valid),
      .cpu_pix       (cpu_pix),
      .cpu_ready     (cpu_ready),
      .fill_start    (fill_start),
      .fill_color    (fill_color),
      .fill_count    (fill_count),
      .fill_busy     (fill_busy),
      .fill_done     (fill_done),
      .frame_restart (frame_restart),
      .pix_index     (pix_index),
      .lcd           (lcd)
   );

   initial clk_16MHz = 1'b0;
   always #5 clk_16MHz = ~clk_16MHz;

   int total = 0;
   int bad   = 0;
   logic stall_mon  = 1'b0;
   logic stall_viol = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_16MHz);
   endtask

   // One driver-side handshake: wait for a request, check it, ack with busy
   // for two cycles. Returns on the falling edge where busy is released.
   task automatic serve(input logic exp_rst, input logic [15:0] exp_dat, input logic pulse_rst);
      int n;
      n = 0;
      while (!(lcd.pix_clk || lcd.reset_cursor) && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", 32'(n < 20), 32'd1);
      chk("req_kind", 32'({lcd.reset_cursor, lcd.pix_clk}), exp_rst ? 32'd2 : 32'd1);
      if (!exp_rst) chk("req_dat", 32'(lcd.pix_data), 32'(exp_dat));
      lcd.lcd_busy = 1'b1;
      if (pulse_rst) frame_restart = 1'b1;
      tick();
      frame_restart = 1'b0;
      chk("req_drop", 32'({lcd.reset_cursor, lcd.pix_clk}), 32'd0);
      if (!exp_rst) chk("dat_hold", 32'(lcd.pix_data), 32'(exp_dat));
      tick();
      lcd.lcd_busy = 1'b0;
   endtask

   always @(negedge clk_16MHz) begin
      #2;
      if (stall_mon && cpu_valid && cpu_ready) stall_viol = 1'b1;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      logic viol;
      resetn        = 1'b0;
      cpu_valid     = 1'b0;
      cpu_pix       = 16'h0;
      fill_start    = 1'b0;
      fill_color    = 16'h0;
      fill_count    = 17'd0;
      frame_restart = 1'b0;
      lcd.lcd_busy  = 1'b1;
      repeat (3) tick();

      // reset state
      chk("rst_pix_clk", 32'(lcd.pix_clk), 32'd0);
      chk("rst_rst_cur", 32'(lcd.reset_cursor), 32'd0);
      chk("rst_pix_data", 32'(lcd.pix_data), 32'd0);
      chk("rst_pix_index", 32'(pix_index), 32'd0);
      chk("rst_fill_busy", 32'(fill_busy), 32'd0);
      chk("rst_fill_done", 32'(fill_done), 32'd0);

      // driver busy for 100 cycles after reset: CPU must wait
      cpu_valid = 1'b1;
      cpu_pix   = 16'hF800;
      resetn    = 1'b1;
      viol      = 1'b0;
      repeat (100) begin
         tick();
         if (cpu_ready || lcd.pix_clk) viol = 1'b1;
      end
      chk("init_stall", 32'(viol), 32'd0);
      lcd.lcd_busy = 1'b0;
      #1;
      chk("first_ready", 32'(cpu_ready), 32'd1);
      chk("first_cyc_pix_clk", 32'(lcd.pix_clk), 32'd0);
      tick();                                 // 2nd cycle with busy low
      chk("cpu_pix_clk", 32'(lcd.pix_clk), 32'd1);
      chk("cpu_pix_data", 32'(lcd.pix_data), 32'hF800);
      chk("issue_not_ready", 32'(cpu_ready), 32'd0);
      cpu_valid = 1'b0;
      tick();
      chk("cpu_pix_clk_hold", 32'(lcd.pix_clk), 32'd1);
      lcd.lcd_busy = 1'b1;
      tick();
      chk("cpu_pix_clk_drop", 32'(lcd.pix_clk), 32'd0);
      chk("cpu_drain_data", 32'(lcd.pix_data), 32'hF800);
      chk("cpu_drain_index", 32'(pix_index), 32'd0);
      tick();
      tick();
      chk("cpu_drain_data2", 32'(lcd.pix_data), 32'hF800);
      lcd.lcd_busy = 1'b0;
      tick();
      chk("cpu_index_1", 32'(pix_index), 32'd1);
      chk("cpu_idle_ready", 32'(cpu_ready), 32'd1);

      // fill of 3 while the CPU waits
      fill_start = 1'b1; fill_color = 16'h07E0; fill_count = 17'd3;
      tick();
      fill_start = 1'b0;
      chk("fill3_busy", 32'(fill_busy), 32'd1);
      cpu_valid = 1'b1; cpu_pix = 16'h1234;
      stall_mon = 1'b1;
      #1;
      chk("fill3_cpu_ready", 32'(cpu_ready), 32'd0);
      repeat (3) serve(1'b0, 16'h07E0, 1'b0);
      stall_mon = 1'b0;
      tick();
      chk("fill3_done", 32'(fill_done), 32'd1);
      chk("fill3_busy_fall", 32'(fill_busy), 32'd0);
      chk("fill3_index", 32'(pix_index), 32'd4);
      chk("fill3_stall", 32'(stall_viol), 32'd0);
      tick();
      chk("fill3_done_1cyc", 32'(fill_done), 32'd0);
      cpu_valid = 1'b0;
      serve(1'b0, 16'h1234, 1'b0);
      tick();
      chk("after_cpu_index", 32'(pix_index), 32'd5);

      // restart during 2nd of 5 fill pixels; fill resumes from pixel 0
      fill_start = 1'b1; fill_color = 16'h001F; fill_count = 17'd5;
      tick();
      fill_start = 1'b0;
      serve(1'b0, 16'h001F, 1'b0);
      serve(1'b0, 16'h001F, 1'b1);
      serve(1'b1, 16'h0000, 1'b0);
      tick();
      chk("restart_index", 32'(pix_index), 32'd0);
      chk("restart_fill_kept", 32'(fill_busy), 32'd1);
      repeat (3) serve(1'b0, 16'h001F, 1'b0);
      tick();
      chk("fill5_index", 32'(pix_index), 32'd3);
      chk("fill5_done", 32'(fill_done), 32'd1);

      // walk to the last frame pixel, then one CPU write wraps the index
      fill_start = 1'b1; fill_color = 16'hAAAA; fill_count = 17'd4;
      tick();
      fill_start = 1'b0;
      repeat (4) serve(1'b0, 16'hAAAA, 1'b0);
      tick();
      chk("last_index", 32'(pix_index), 32'(FP - 1));
      cpu_valid = 1'b1; cpu_pix = 16'h5555;
      tick();
      cpu_valid = 1'b0;
      serve(1'b0, 16'h5555, 1'b0);
      tick();
      chk("wrap_index", 32'(pix_index), 32'd0);

      // restart and CPU in the same cycle: restart goes first
      frame_restart = 1'b1; cpu_valid = 1'b1; cpu_pix = 16'hBEEF;
      #1;
      chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
      tick();
      frame_restart = 1'b0;
      serve(1'b1, 16'h0000, 1'b0);
      tick();
      chk("post_rst_ready", 32'(cpu_ready), 32'd1);
      tick();
      cpu_valid = 1'b0;
      serve(1'b0, 16'hBEEF, 1'b0);
      tick();
      chk("post_rst_index", 32'(pix_index), 32'd1);

      // zero-length fill
      fill_start = 1'b1; fill_color = 16'h1111; fill_count = 17'd0;
      tick();
      fill_start = 1'b0;
      chk("fill0_done", 32'(fill_done), 32'd1);
      chk("fill0_busy", 32'(fill_busy), 32'd0);
      tick();
      chk("fill0_done_1cyc", 32'(fill_done), 32'd0);
      chk("fill0_no_pix_clk", 32'(lcd.pix_clk), 32'd0);

      // reset while a fill pixel is in ISSUE
      fill_start = 1'b1; fill_color = 16'h0F0F; fill_count = 17'd4;
      tick();
      fill_start = 1'b0;
      tick();
      chk("mid_issue_pix_clk", 32'(lcd.pix_clk), 32'd1);
      resetn = 1'b0;
      tick();
      chk("mid_rst_pix_clk", 32'(lcd.pix_clk), 32'd0);
      chk("mid_rst_fill_busy", 32'(fill_busy), 32'd0);
      chk("mid_rst_fill_done", 32'(fill_done), 32'd0);
      chk("mid_rst_index", 32'(pix_index), 32'd0);
      resetn = 1'b1;
      viol = 1'b0;
      repeat (6) begin
         tick();
         if (fill_done || lcd.pix_clk || lcd.reset_cursor) viol = 1'b1;
      end
      chk("mid_rst_quiet", 32'(viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
